drive_sequencer: RTL

DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

---
 rtl/drive_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/drive_sequencer.sv
`timescale 1ns/1ps
// Duty ramp and H-bridge direction sequencer: slews two PWM duties per period
// and enforces ramp-down plus dead time before a direction change.
module drive_sequencer #(
    parameter int unsigned PERIOD = 250000,
    parameter int unsigned STEP   = 25000,
    parameter int unsigned DEAD   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_wrap,
    input  logic [19:0] tgt_a,
    input  logic [19:0] tgt_b,
    input  logic [3:0]  dir_req,
    input  logic        stop,
    output logic [19:0] duty_a,
    output logic [19:0] duty_b,
    output logic [3:0]  in,
    output logic [2:0]  state,
    output logic        dir_err
);

    localparam int unsigned DUTY_W = 20;
    localparam int unsigned DEAD_W = (DEAD < 2) ? 1 : $clog2(DEAD + 1);
    localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] STEP_V   = DUTY_W'(STEP);
    localparam logic [DEAD_W-1:0] DEAD_V   = DEAD_W'(DEAD);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_RAMP_DOWN = 3'd2,
        S_COAST     = 3'd3,
        S_STOPPED   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [DUTY_W-1:0]   duty_a_q, duty_a_d, duty_b_q, duty_b_d;
    logic [3:0]          in_q, in_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic                dir_err_q, dir_err_d;

    logic                dir_ok;
    logic [DUTY_W-1:0]   up_a, up_b, down_a, down_b;

    // One slew step from cur toward tgt, landing exactly on tgt when within STEP.
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                       input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W-1:0] res;
        if (tgt >= cur) begin
            res = ((tgt - cur) <= STEP_V) ? tgt : cur + STEP_V;
        end else begin
            res = ((cur - tgt) <= STEP_V) ? tgt : cur - STEP_V;
        end
        return res;
    endfunction

    function automatic logic [DUTY_W-1:0] clamp(input logic [DUTY_W-1:0] t);
        return (t > PERIOD_V) ? PERIOD_V : t;
    endfunction

    assign dir_ok = (dir_req[1:0] != 2'b11) && (dir_req[3:2] != 2'b11);
    assign up_a   = step_toward(duty_a_q, clamp(tgt_a));
    assign up_b   = step_toward(duty_b_q, clamp(tgt_b));
    assign down_a = step_toward(duty_a_q, '0);
    assign down_b = step_toward(duty_b_q, '0);

    always_comb begin
        state_d   = state_q;
        duty_a_d  = duty_a_q;
        duty_b_d  = duty_b_q;
        in_d      = in_q;
        dead_d    = dead_q;
        dir_err_d = 1'b0;
        if (stop) begin
            state_d  = S_STOPPED;
            duty_a_d = '0;
            duty_b_d = '0;
            in_d     = '0;
        end else if (state_q == S_STOPPED) begin
            state_d = S_COAST;
            dead_d  = DEAD_V;
        end else if (pwm_wrap) begin
            dir_err_d = !dir_ok;
            unique case (state_q)
                S_IDLE: begin
                    if (dir_ok) begin
                        in_d    = dir_req;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (dir_ok && (dir_req != in_q)) begin
                        state_d  = S_RAMP_DOWN;
                        duty_a_d = down_a;
                        duty_b_d = down_b;
                    end else begin
                        duty_a_d = up_a;
                        duty_b_d = up_b;
                    end
                end
                S_RAMP_DOWN: begin
                    duty_a_d = down_a;
                    duty_b_d = down_b;
                    if ((down_a == '0) && (down_b == '0)) begin
                        state_d = S_COAST;
                        in_d    = '0;
                        dead_d  = DEAD_V;
                    end
                end
                S_COAST: begin
                    // Direction is sampled only at dead-time expiry.
                    if (dead_q > DEAD_W'(1)) begin
                        dead_d = dead_q - DEAD_W'(1);
                    end else begin
                        in_d    = dir_ok ? dir_req : 4'b0000;
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            duty_a_q  <= '0;
            duty_b_q  <= '0;
            in_q      <= '0;
            dead_q    <= '0;
            dir_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_a_q  <= duty_a_d;
            duty_b_q  <= duty_b_d;
            in_q      <= in_d;
            dead_q    <= dead_d;
            dir_err_q <= dir_err_d;
        end
    end

    assign duty_a  = duty_a_q;
    assign duty_b  = duty_b_q;
    assign in      = in_q;
    assign state   = 3'(state_q);
    assign dir_err = dir_err_q;

endmodule
